// File: rtl/snn_frame_loader_if.sv
// Signal bundle between the frame loader and its neighbours: UART byte stream,
// input-RAM write port, snn_core handshake, result/status outputs.
interface snn_frame_loader_if #(
  parameter int ADDR_W   = 10,
  parameter int PIX_BITS = 1
);
  logic                rx_rdy;
  logic [7:0]          rx_data;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [PIX_BITS-1:0] ram_wdata;
  logic [ADDR_W-1:0]   core_addr;
  logic                core_start;
  logic                core_done;
  logic [3:0]          core_digit;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                tx_rdy;
  logic                busy;
  logic                overrun_err;
  logic                timeout_err;
  logic [7:0]          led;

  // The loader side.
  modport master (
    input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
    output ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data,
           busy, overrun_err, timeout_err, led
  );

  // The environment side (UART, RAM, core).
  modport slave (
    output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
    input  ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data,
           busy, overrun_err, timeout_err, led
  );
endinterface

// File: rtl/snn_frame_loader.sv
// UART-to-core frame controller: unpacks received bytes LSB-first into pixels,
// fills the input RAM, runs snn_core and returns {RESULT_PREFIX,digit} over UART.
module snn_frame_loader #(
  parameter int         NUM_PIXELS    = 784,
  parameter int         PIX_BITS      = 1,
  parameter int         ADDR_W        = 10,
  parameter int         TIMEOUT_CYC   = 2_500_000,
  parameter logic [3:0] RESULT_PREFIX = 4'h3
) (
  input  logic               clk,
  input  logic               rst_n,
  snn_frame_loader_if.master bus
);

  localparam logic [2:0] RX_WAIT = 3'd0;
  localparam logic [2:0] UNPACK  = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] CORE    = 3'd3;
  localparam logic [2:0] TX_WAIT = 3'd4;

  localparam int                 TIMER_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0]  PIX_LAST   = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [2:0]         SUB_LAST   = 3'(8 / PIX_BITS - 1);

  logic [2:0]         state_reg,      state_next;
  logic [ADDR_W-1:0]  pix_cnt_reg,    pix_cnt_next;
  logic [2:0]         sub_cnt_reg,    sub_cnt_next;
  logic [7:0]         shreg_reg,      shreg_next;
  logic [7:0]         hold_reg,       hold_next;
  logic               hold_full_reg,  hold_full_next;
  logic [TIMER_W-1:0] timer_reg,      timer_next;
  logic [7:0]         tx_data_reg,    tx_data_next;
  logic [7:0]         led_reg,        led_next;
  logic               core_start_reg;
  logic               overrun_reg,    overrun_next;
  logic               timeout_reg,    timeout_next;

  always_comb begin
    state_next     = state_reg;
    pix_cnt_next   = pix_cnt_reg;
    sub_cnt_next   = sub_cnt_reg;
    shreg_next     = shreg_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    timer_next     = '0;
    tx_data_next   = tx_data_reg;
    led_next       = led_reg;
    overrun_next   = 1'b0;
    timeout_next   = 1'b0;

    case (state_reg)
      RX_WAIT: begin
        if (hold_full_reg) begin
          // Drain the buffered byte; a byte arriving now refills the buffer.
          shreg_next   = hold_reg;
          sub_cnt_next = '0;
          state_next   = UNPACK;
          if (bus.rx_rdy) begin
            hold_next = bus.rx_data;
          end else begin
            hold_full_next = 1'b0;
          end
        end else if (bus.rx_rdy) begin
          shreg_next   = bus.rx_data;
          sub_cnt_next = '0;
          state_next   = UNPACK;
        end else if (pix_cnt_reg != '0) begin
          if (timer_reg == TIMER_LAST) begin
            pix_cnt_next = '0;
            timeout_next = 1'b1;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
      end

      UNPACK: begin
        shreg_next   = shreg_reg >> PIX_BITS;
        sub_cnt_next = sub_cnt_reg + 1'b1;
        // The final pixel holds the counter; START clears it, so it never wraps.
        if (pix_cnt_reg != PIX_LAST) begin
          pix_cnt_next = pix_cnt_reg + 1'b1;
        end
        if (sub_cnt_reg == SUB_LAST) begin
          state_next = (pix_cnt_reg == PIX_LAST) ? START : RX_WAIT;
        end
      end

      START: begin
        pix_cnt_next = '0;
        state_next   = CORE;
      end

      CORE: begin
        if (bus.core_done) begin
          tx_data_next = {RESULT_PREFIX, bus.core_digit};
          led_next     = {RESULT_PREFIX, bus.core_digit};
          state_next   = TX_WAIT;
        end
      end

      TX_WAIT: begin
        if (bus.tx_rdy) begin
          state_next = RX_WAIT;
        end
      end

      default: begin
        state_next = RX_WAIT;
      end
    endcase

    if (bus.rx_rdy) begin
      if (state_reg == UNPACK || state_reg == START) begin
        if (hold_full_reg) begin
          overrun_next = 1'b1;
        end else begin
          hold_next      = bus.rx_data;
          hold_full_next = 1'b1;
        end
      end else if (state_reg == CORE || state_reg == TX_WAIT) begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RX_WAIT;
      pix_cnt_reg    <= '0;
      sub_cnt_reg    <= '0;
      shreg_reg      <= '0;
      hold_reg       <= '0;
      hold_full_reg  <= 1'b0;
      timer_reg      <= '0;
      tx_data_reg    <= '0;
      led_reg        <= '0;
      core_start_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pix_cnt_reg    <= pix_cnt_next;
      sub_cnt_reg    <= sub_cnt_next;
      shreg_reg      <= shreg_next;
      hold_reg       <= hold_next;
      hold_full_reg  <= hold_full_next;
      timer_reg      <= timer_next;
      tx_data_reg    <= tx_data_next;
      led_reg        <= led_next;
      // Registered so the start pulse lands two cycles after the final RAM write.
      core_start_reg <= (state_reg == START);
      overrun_reg    <= overrun_next;
      timeout_reg    <= timeout_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIX_BITS; gi++) begin : g_wdata
      assign bus.ram_wdata[gi] = shreg_reg[gi];
    end
  endgenerate

  assign bus.ram_we      = (state_reg == UNPACK);
  assign bus.ram_addr    = (state_reg == UNPACK) ? pix_cnt_reg : bus.core_addr;
  assign bus.core_start  = core_start_reg;
  assign bus.tx_start    = (state_reg == TX_WAIT) && bus.tx_rdy;
  assign bus.tx_data     = tx_data_reg;
  assign bus.led         = led_reg;
  assign bus.busy        = !((state_reg == RX_WAIT) && (pix_cnt_reg == '0));
  assign bus.overrun_err = overrun_reg;
  assign bus.timeout_err = timeout_reg;

endmodule
